// File: rtl/qspi_flash_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qspi_flash_mem                                                           |
// | Read-only quad-SPI flash byte fetcher (0xAB wake, 0xEB quad I/O read).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module qspi_flash_mem #(
  parameter int WAKE_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_nes,
  output logic        ready,
  input  logic        read_en,
  input  logic [23:0] addr,
  output logic [7:0]  rdata,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  inout  wire         spi_mosi,
  inout  wire         spi_miso,
  inout  wire         flash_wp_n,
  inout  wire         flash_hold_n
);

  localparam logic [7:0] c_CMD_WAKE = 8'hAB;
  localparam logic [7:0] c_CMD_READ = 8'hEB;
  localparam logic [3:0] c_OE_IDLE  = 4'b1101;
  localparam logic [3:0] c_OUT_IDLE = 4'b1100;
  localparam int         c_WW_W     = (WAKE_WAIT < 2) ? 1 : $clog2(WAKE_WAIT + 1);

  typedef enum logic [3:0] {
    ST_WAKE      = 4'd0,
    ST_WAKE_WAIT = 4'd1,
    ST_IDLE      = 4'd2,
    ST_CMD       = 4'd3,
    ST_ADDR      = 4'd4,
    ST_MODE      = 4'd5,
    ST_DUMMY     = 4'd6,
    ST_DATA      = 4'd7,
    ST_END       = 4'd8
  } state_t;

  state_t              r_state;
  logic                r_ph;
  logic [2:0]          r_cnt;
  logic [c_WW_W-1:0]   r_wcnt;
  logic [23:0]         r_sh;
  logic [7:0]          r_rx;
  logic                r_ready;
  logic [7:0]          r_rdata;
  logic                r_sclk;
  logic                r_cs_n;
  logic [3:0]          r_oe;
  logic [3:0]          r_out;

  logic [3:0]          w_io_in;
  logic [2:0]          w_last;
  state_t              w_next;

  assign w_io_in = {flash_hold_n, flash_wp_n, spi_miso, spi_mosi};

  // Last SCLK index and successor for each shifting phase.
  always_comb begin
    w_last = 3'd7;
    w_next = ST_IDLE;
    case (r_state)
      ST_WAKE:  w_next = ST_WAKE_WAIT;
      ST_CMD:   w_next = ST_ADDR;
      ST_ADDR:  begin w_last = 3'd5; w_next = ST_MODE;  end
      ST_MODE:  begin w_last = 3'd1; w_next = ST_DUMMY; end
      ST_DUMMY: begin w_last = 3'd3; w_next = ST_DATA;  end
      ST_DATA:  begin w_last = 3'd1; w_next = ST_END;   end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_WAKE;
      r_ph    <= 1'b0;
      r_cnt   <= 3'd0;
      r_wcnt  <= '0;
      r_sh    <= 24'h0;
      r_rx    <= 8'h00;
      r_ready <= 1'b0;
      r_rdata <= 8'h00;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_oe    <= c_OE_IDLE;
      r_out   <= c_OUT_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sclk <= 1'b0;
          r_cs_n <= 1'b1;
          r_out  <= c_OUT_IDLE;
          if (r_ready && read_en) begin
            r_ready <= 1'b0;
            r_sh    <= addr;
            r_cnt   <= 3'd0;
            r_ph    <= 1'b0;
            r_oe    <= c_OE_IDLE;
            r_state <= ST_CMD;
          end else begin
            r_ready <= run_nes;
            r_oe    <= run_nes ? c_OE_IDLE : 4'b0000;
          end
        end

        ST_WAKE_WAIT: begin
          r_sclk <= 1'b0;
          r_cs_n <= 1'b1;
          r_oe   <= c_OE_IDLE;
          r_out  <= c_OUT_IDLE;
          if (r_wcnt == c_WW_W'(WAKE_WAIT)) begin
            r_wcnt  <= '0;
            r_ready <= run_nes;
            r_state <= ST_IDLE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end

        ST_END: begin
          r_sclk  <= 1'b0;
          r_cs_n  <= 1'b1;
          r_oe    <= c_OE_IDLE;
          r_out   <= c_OUT_IDLE;
          r_rdata <= r_rx;
          r_state <= ST_IDLE;
        end

        default: begin
          // Command phases spend one cycle asserting CS before the first SCLK.
          if ((r_state == ST_WAKE || r_state == ST_CMD) && r_cs_n) begin
            r_cs_n <= 1'b0;
          end else if (!r_ph) begin
            r_sclk <= 1'b0;
            r_ph   <= 1'b1;
            case (r_state)
              ST_WAKE: r_out[0] <= c_CMD_WAKE[3'd7 - r_cnt];
              ST_CMD:  r_out[0] <= c_CMD_READ[3'd7 - r_cnt];
              ST_ADDR: begin
                r_oe  <= 4'b1111;
                r_out <= r_sh[23:20];
                r_sh  <= {r_sh[19:0], 4'h0};
              end
              ST_MODE: begin
                r_oe  <= 4'b1111;
                r_out <= 4'h0;
              end
              default: r_oe <= 4'b0000;
            endcase
          end else begin
            r_sclk <= 1'b1;
            r_ph   <= 1'b0;
            if (r_state == ST_DATA) r_rx <= {r_rx[3:0], w_io_in};
            if (r_cnt == w_last) begin
              r_cnt   <= 3'd0;
              r_state <= w_next;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
      endcase
    end
  end

  assign ready        = r_ready;
  assign rdata        = r_rdata;
  assign spi_sclk     = r_sclk;
  assign spi_cs_n     = r_cs_n;
  assign spi_mosi     = r_oe[0] ? r_out[0] : 1'bz;
  assign spi_miso     = r_oe[1] ? r_out[1] : 1'bz;
  assign flash_wp_n   = r_oe[2] ? r_out[2] : 1'bz;
  assign flash_hold_n = r_oe[3] ? r_out[3] : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_qspi_flash_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qspi_flash_mem                                                        |
// | Scoreboard bench for qspi_flash_mem with a behavioural quad-SPI flash.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_qspi_flash_mem;

  localparam int WW = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_nes = 1'b1;
  logic        read_en = 1'b0;
  logic [23:0] addr = 24'h0;
  wire         ready;
  wire  [7:0]  rdata;
  wire         spi_sclk;
  wire         spi_cs_n;
  wire         io0, io1, io2, io3;

  logic        fl_drv = 1'b0;
  logic [3:0]  fl_val = 4'h0;
  logic        park_drv = 1'b0;
  wire  [3:0]  tb_val = park_drv ? 4'h0 : fl_val;
  wire         tb_en  = fl_drv | park_drv;
  wire  [3:0]  io_bus = {io3, io2, io1, io0};

  assign io0 = tb_en ? tb_val[0] : 1'bz;
  assign io1 = tb_en ? tb_val[1] : 1'bz;
  assign io2 = tb_en ? tb_val[2] : 1'bz;
  assign io3 = tb_en ? tb_val[3] : 1'bz;

  qspi_flash_mem #(.WAKE_WAIT(WW)) dut (
    .clk          (clk),
    .reset        (reset),
    .run_nes      (run_nes),
    .ready        (ready),
    .read_en      (read_en),
    .addr         (addr),
    .rdata        (rdata),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (io0),
    .spi_miso     (io1),
    .flash_wp_n   (io2),
    .flash_hold_n (io3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Flash array contents: a few fixed bytes, arithmetic pattern elsewhere.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h55AACC: return 8'h3C;
      24'h000000: return 8'h12;
      24'hFFFFFF: return 8'hEF;
      default:    return 8'(a[7:0] * 8'd13) ^ a[15:8] ^ 8'(a[23:16] + 8'h5A);
    endcase
  endfunction

  // ---------------- behavioural flash ----------------
  int          fl_rise = 0;
  int          wake_seen = 0;
  logic [7:0]  fl_cmd = 8'h0;
  logic [23:0] fl_addr = 24'h0;
  logic [7:0]  fl_mode = 8'h0;
  logic [7:0]  fl_data = 8'h0;
  logic [23:0] addr_q[$];
  logic [7:0]  exp_q[$];

  always @(posedge spi_sclk) if (!spi_cs_n) begin
    if (fl_rise < 8)       fl_cmd  = {fl_cmd[6:0], io0};
    else if (fl_rise < 14) fl_addr = {fl_addr[19:0], io_bus};
    else if (fl_rise < 16) fl_mode = {fl_mode[3:0], io_bus};
    fl_rise = fl_rise + 1;
    if (fl_rise == 16) begin
      check("read_cmd", 32'(fl_cmd), 32'hEB);
      check("mode_bits", 32'(fl_mode), 32'h00);
      if (addr_q.size() == 0) check("addr_queue", 32'(fl_addr), 32'hFFFF_FFFF);
      else check("addr_bus", 32'(fl_addr), 32'(addr_q.pop_front()));
      fl_data = mem_byte(fl_addr);
    end
  end

  always @(negedge spi_sclk) if (!spi_cs_n) begin
    if (fl_rise == 20) begin
      fl_drv = 1'b1;
      fl_val = fl_data[7:4];
    end else if (fl_rise == 21) begin
      fl_val = fl_data[3:0];
    end
  end

  always @(posedge spi_cs_n) begin
    if (fl_rise == 8 && fl_cmd == 8'hAB) wake_seen++;
    fl_rise = 0;
    fl_drv  = 1'b0;
  end

  // ---------------- monitor / scoreboard ----------------
  int acc_cyc = 0;
  bit pend = 0;
  bit prev_ready = 0;
  int cs_hi_run = 0;
  bit had_txn = 0;
  int cs_falls = 0;

  always @(negedge clk) begin
    if (!reset) begin
      pend = 0;
      prev_ready = 0;
      had_txn = 0;
      cs_hi_run = 0;
    end else begin
      if (pend && ready && !prev_ready) begin
        check("read_latency", 32'(cyc - acc_cyc), 32'd47);
        if (exp_q.size() == 0) check("rdata_queue", 32'(rdata), 32'hFFFF_FFFF);
        else check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
        pend = 0;
      end
      if (ready && read_en) begin
        acc_cyc = cyc + 1;
        pend = 1;
      end
      prev_ready = ready;
      if (spi_cs_n) begin
        cs_hi_run++;
      end else begin
        if (cs_hi_run > 0) begin
          if (had_txn) check("cs_gap", 32'(cs_hi_run >= 2), 32'd1);
          cs_falls++;
        end
        had_txn = 1;
        cs_hi_run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic release_and_wake();
    int w0 = wake_seen;
    int c0;
    int n = 0;
    @(negedge clk);
    reset = 1'b1;
    c0 = cyc;
    while (!ready && n < WW + 100) begin
      @(negedge clk);
      n++;
    end
    check("wake_latency", 32'(cyc - c0), 32'(18 + WW));
    check("wake_cmd", 32'(wake_seen - w0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [23:0] a);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    addr = a;
    read_en = 1'b1;
    exp_q.push_back(mem_byte(a));
    addr_q.push_back(a);
    @(posedge clk); #1;
    read_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int f0;
    logic [23:0] ra;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_io0", 32'(io0), 32'd0);
    check("rst_io2", 32'(io2), 32'd1);
    check("rst_io3", 32'(io3), 32'd1);
    release_and_wake();

    do_read(24'h55AACC);
    wait_idle();

    do_read(24'h000000);
    do_read(24'hFFFFFF);
    wait_idle();

    // Parked: requests ignored, bus released.
    run_nes = 1'b0;
    @(posedge clk); #1;
    check("park_ready", 32'(ready), 32'd0);
    park_drv = 1'b1;
    f0 = cs_falls;
    addr = 24'h123456;
    read_en = 1'b1;
    @(posedge clk); #1;
    read_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("park_cs_activity", 32'(cs_falls - f0), 32'd0);
    check("park_cs_n", 32'(spi_cs_n), 32'd1);
    check("park_io_released", 32'(io_bus), 32'h0);
    park_drv = 1'b0;
    run_nes = 1'b1;
    @(posedge clk); #1;
    check("unpark_ready", 32'(ready), 32'd1);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ra = 24'($urandom);
      do_read(ra);
    end
    wait_idle();

    // Reset while the address nibbles are on the bus.
    do_read(24'($urandom));
    repeat (20) @(posedge clk);
    #3;
    check("abort_in_addr", 32'(fl_rise > 8 && fl_rise < 14), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_ready", 32'(ready), 32'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    release_and_wake();
    do_read(24'hABCDEF);
    wait_idle();

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/qspi_flash_mem.md
# qspi_flash_mem

Read-only quad-SPI flash controller that fetches single bytes from a 24-bit flash address space for the NES core (ROM/cartridge data). After reset it wakes the flash with a Release Power-Down command. It then services one-byte reads with the Fast Read Quad I/O command (0xEB) using a ready/read_en handshake. It sits between the NES memory arbiter and the board's SPI flash pins, and releases the bus when the core is not running.

## Interface
- `WAKE_WAIT`, default 64: `clk` cycles after the 0xAB command, with CS high, before `ready` may first assert.
- `clk`  in  1  system clock; SPI clock is `clk`/2.
- `reset`  in  1  asynchronous, active-low reset.
- `run_nes`  in  1  enable; low = controller parked, bus released, requests ignored.
- `ready`  out  1  high = idle, able to accept `read_en`; on return high after a read, `rdata` is valid.
- `read_en`  in  1  read request, sampled only while `ready`=1.
- `addr`  in  24  byte address, captured with `read_en`.
- `rdata`  out  8  last byte read; held until the next read completes.
- `spi_sclk`  out  1  flash clock, SPI mode 0 (idles low).
- `spi_cs_n`  out  1  flash chip select, active low.
- `spi_mosi`  inout  1  IO0.
- `spi_miso`  inout  1  IO1.
- `flash_wp_n`  inout  1  IO2.
- `flash_hold_n`  inout  1  IO3.

## Operation
- **States:** WAKE → WAKE_WAIT → IDLE → CMD → ADDR → MODE → DUMMY → DATA → END → IDLE.
- **Reset values:**
  - `ready`=0, `rdata`=0x00, `spi_cs_n`=1, `spi_sclk`=0.
  - IO0 driven 0; IO2/IO3 driven 1; IO1 high-Z.
  - State = WAKE.
- **WAKE:**
  - CS low; shift 0xAB MSB-first on IO0 (8 SCLK); CS high.
  - Hold WAKE_WAIT for `WAKE_WAIT` cycles, then go to IDLE.
- **IDLE:**
  - `ready`=run_nes.
  - `read_en`=1 with `ready`=1 latches `addr` and enters CMD.
- **CMD:** 0xEB MSB-first on IO0, single-line, 8 SCLK. IO2/IO3 driven 1 (WP/HOLD inactive).
- **ADDR:** 24-bit address on IO3..IO0, most significant nibble first, 6 SCLK.
- **MODE:** 0x00 on IO3..IO0, 2 SCLK. This prevents continuous-read mode.
- **DUMMY:** 4 SCLK with all four IOs high-Z.
- **DATA:**
  - 2 SCLK, IOs high-Z.
  - High nibble captured first, then low nibble, into `rdata`.
- **END:** CS high, IOs return to reset drive, then IDLE.
- **IO drivers:** outside quad phases IO0/IO2/IO3 are driven and IO1 is input. During DUMMY/DATA all four are inputs.
- **`run_nes`=0:**
  - Checked in IDLE only: `ready`=0, CS high, all four IOs high-Z.
  - A read in progress always completes.
  - Wake is performed regardless of `run_nes`.
- **Reset mid-operation:** immediate abort; CS high; all outputs return to reset values. The wake sequence is reissued.

## Timing
- Each SCLK period is two `clk` cycles.
  - Phase A (`spi_sclk`=0): output data updated.
  - Phase B (`spi_sclk`=1): rising edge.
- Input nibbles are sampled on the `clk` edge that drives SCLK high.
- CS asserts one `clk` cycle before the first phase A.
- CS deasserts one `clk` cycle after the last phase B, with SCLK low.
- **Read latency:**
  - `read_en` accepted on edge N → `ready`=0 from N+1.
  - 22 SCLK = 44 cycles of transfer, plus CS setup and hold.
  - `ready`=1 and `rdata` valid at edge N+47.
- **Back-to-back reads:** a new `read_en` may be accepted on the same edge `ready` is first seen high. CS high time between transactions is at least 2 `clk` cycles.
- **Initial ready:** first `ready` = 1 + 16 + 1 + `WAKE_WAIT` cycles after reset release.

## Test plan
- **Reset:** hold `reset`=0 → `ready`=0, `spi_cs_n`=1, `spi_sclk`=0, `rdata`=0x00. Release → IO0 carries 10101011 (0xAB) over 8 SCLK rises, then CS high.
- **Wake completion:** `ready` asserts exactly 1+16+1+`WAKE_WAIT` cycles after reset release, with `run_nes`=1.
- **Single read:** `addr`=0x55AACC, flash model returns 0x3C.
  - IO0 shows 0xEB; IO3..0 show nibbles 5,5,A,A,C,C then 0,0; 4 dummy SCLK.
  - `rdata`=0x3C when `ready` rises 47 cycles after acceptance.
- **Back-to-back:** reads of 0x000000 then 0xFFFFFF (model data 0x12, 0xEF) → `rdata` = 0x12 then 0xEF. CS high for ≥2 cycles between transactions.
- **`run_nes`=0:**
  - `ready`=0, a `read_en` pulse produces no CS activity, IOs high-Z.
  - Raise `run_nes` → `ready`=1 next cycle.
- **Reset mid-read:** assert `reset` during ADDR → CS high asynchronously. After release, a full wake sequence, then a normal read succeeds.
